// File: rtl/prng_lfsr_multi.sv
// prng_lfsr_multi: Fibonacci LFSR random source that produces OUT_W bits per step.
// Words are delivered over a valid/ready handshake. The block also provides a
// registered command (halt/run/load), a seed register with a zero-seed guard,
// and a saturating count of words delivered since the last seed load.
module prng_lfsr_multi #(
    parameter int               DAT_W    = 25,
    parameter logic [DAT_W-1:0] TAP_MASK = 25'h1000004,
    parameter int               OUT_W    = 8,
    parameter logic [DAT_W-1:0] SEED_DEF = 25'h0000001,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [1:0]       prng_cmd,
    input  logic [DAT_W-1:0] seed_dat,
    input  logic             seed_we,
    output logic [OUT_W-1:0] rnd_dat,
    output logic             rnd_vld,
    input  logic             rnd_rdy,
    output logic [DAT_W-1:0] lfsr_st,
    output logic [CNT_W-1:0] seed_age
);

    // Command 3 is reserved. It falls into the default branch and behaves as halt.
    typedef enum logic [1:0] {
        CMD_HALT = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_LOAD = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_t;

    cmd_t             cmd_reg;
    logic [DAT_W-1:0] seed_reg;
    logic [DAT_W-1:0] step_src;
    logic [DAT_W-1:0] step_nxt;
    logic [DAT_W-1:0] load_val;
    logic             accept;
    logic             step_en;

    assign accept  = rnd_vld & rnd_rdy;
    // A new word is produced when the output slot is empty, or is being emptied this cycle.
    assign step_en = (cmd_reg == CMD_RUN) && (!rnd_vld || rnd_rdy);

    // The all-zero state is a lock-up. Only reset can reach it, so substitute the default seed here.
    assign step_src = (lfsr_st == '0) ? SEED_DEF : lfsr_st;
    assign load_val = (seed_reg == '0) ? SEED_DEF : seed_reg;

    // Unroll OUT_W single-bit Fibonacci shifts. The new bit enters at the LSB.
    always_comb begin
        step_nxt = step_src;
        for (int i = 0; i < OUT_W; i++) begin
            step_nxt = {step_nxt[DAT_W-2:0], ^(step_nxt & TAP_MASK)};
        end
    end

    // Register the command. It acts on the following edge.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) cmd_reg <= CMD_HALT;
        else        cmd_reg <= cmd_t'(prng_cmd);
    end

    // Capture the seed. A load issued in the same cycle still sees the previous value.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)       seed_reg <= '0;
        else if (seed_we) seed_reg <= seed_dat;
    end

    // LFSR state and output word slot.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lfsr_st <= '0;
            rnd_dat <= '0;
            rnd_vld <= 1'b0;
        end else begin
            case (cmd_reg)
                CMD_LOAD: begin
                    // A load flushes the pending word, even one that is accepted in this same cycle.
                    lfsr_st <= load_val;
                    rnd_vld <= 1'b0;
                end
                CMD_RUN: begin
                    if (step_en) begin
                        lfsr_st <= step_nxt;
                        rnd_dat <= step_nxt[OUT_W-1:0];
                        rnd_vld <= 1'b1;
                    end
                end
                default: begin
                    // In halt the LFSR is frozen. A word already in the slot can still be drained.
                    if (accept) rnd_vld <= 1'b0;
                end
            endcase
        end
    end

    // Count accepted words since the last load. The count saturates at all-ones.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            seed_age <= '0;
        else if (cmd_reg == CMD_LOAD)
            seed_age <= '0;
        else if (accept && (seed_age != '1))
            seed_age <= seed_age + CNT_W'(1);
    end

endmodule
